// File: rtl/ocp_arbiter2.sv
// Two-master OCP arbiter: one capture slot per master, round-robin grant, watchdog error completion.
// Command reaches the slave 1 cycle after capture at the earliest; responses are registered (+1 cycle); a full slot deasserts SCmdAccept.
module ocp_arbiter2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BEN_WIDTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_M0_MAddr,
  input  logic [2:0]            i_M0_MCmd,
  input  logic [DATA_WIDTH-1:0] i_M0_MData,
  input  logic [BEN_WIDTH-1:0]  i_M0_MByteEn,
  output logic                  o_M0_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_M0_SData,
  output logic [1:0]            o_M0_SResp,
  input  logic [ADDR_WIDTH-1:0] i_M1_MAddr,
  input  logic [2:0]            i_M1_MCmd,
  input  logic [DATA_WIDTH-1:0] i_M1_MData,
  input  logic [BEN_WIDTH-1:0]  i_M1_MByteEn,
  output logic                  o_M1_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_M1_SData,
  output logic [1:0]            o_M1_SResp,
  output logic [ADDR_WIDTH-1:0] o_S_MAddr,
  output logic [2:0]            o_S_MCmd,
  output logic [DATA_WIDTH-1:0] o_S_MData,
  output logic [BEN_WIDTH-1:0]  o_S_MByteEn,
  input  logic                  i_S_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_S_SData,
  input  logic [1:0]            i_S_SResp
);

  localparam logic [2:0] CMD_IDLE  = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_ERR  = 2'd3;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          state, state_n;
  logic            owner, owner_n;
  logic            last_grant, last_grant_n;
  logic [TW-1:0]   timer, timer_n;
  logic            done, rsp_fire, rsp_err;
  logic [1:0]      rsp_code;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic [1:0]            pend;
  logic [ADDR_WIDTH-1:0] in_addr [2];
  logic [2:0]            in_cmd  [2];
  logic [DATA_WIDTH-1:0] in_data [2];
  logic [BEN_WIDTH-1:0]  in_ben  [2];
  logic [ADDR_WIDTH-1:0] slot_addr [2];
  logic [2:0]            slot_cmd  [2];
  logic [DATA_WIDTH-1:0] slot_data [2];
  logic [BEN_WIDTH-1:0]  slot_ben  [2];

  assign in_addr[0] = i_M0_MAddr;
  assign in_cmd[0]  = i_M0_MCmd;
  assign in_data[0] = i_M0_MData;
  assign in_ben[0]  = i_M0_MByteEn;
  assign in_addr[1] = i_M1_MAddr;
  assign in_cmd[1]  = i_M1_MCmd;
  assign in_data[1] = i_M1_MData;
  assign in_ben[1]  = i_M1_MByteEn;

  assign o_M0_SCmdAccept = ~pend[0];
  assign o_M1_SCmdAccept = ~pend[1];

  // Capture and release never overlap: capture needs an empty slot, release needs the owner's full one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        slot_addr[i] <= '0;
        slot_cmd[i]  <= CMD_IDLE;
        slot_data[i] <= '0;
        slot_ben[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && in_cmd[i] != CMD_IDLE) begin
          pend[i]      <= 1'b1;
          slot_addr[i] <= in_addr[i];
          slot_cmd[i]  <= in_cmd[i];
          slot_data[i] <= in_data[i];
          slot_ben[i]  <= in_ben[i];
        end else if (done && owner == 1'(i)) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      timer      <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_grant <= last_grant_n;
      timer      <= timer_n;
    end
  end

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_grant_n = last_grant;
    timer_n      = timer;
    done         = 1'b0;
    rsp_fire     = 1'b0;
    rsp_err      = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend != 2'b00) begin
          state_n = S_ISSUE;
          timer_n = '0;
          owner_n = (pend == 2'b11) ? ~last_grant : pend[1];
        end
      end
      S_ISSUE: begin
        timer_n = timer + 1'b1;
        if (i_S_SCmdAccept && slot_cmd[owner] != CMD_READ) begin
          done = 1'b1;
        end else if (i_S_SCmdAccept && i_S_SResp != RESP_NULL) begin
          done     = 1'b1;
          rsp_fire = 1'b1;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          // An accepted read still owes a response, so it times out as an error too.
          done     = 1'b1;
          rsp_fire = (slot_cmd[owner] == CMD_READ);
          rsp_err  = 1'b1;
        end else if (i_S_SCmdAccept) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_n = timer + 1'b1;
        if (i_S_SResp != RESP_NULL) begin
          done     = 1'b1;
          rsp_fire = 1'b1;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          done     = 1'b1;
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (done) begin
      state_n      = S_IDLE;
      last_grant_n = owner;
    end
  end

  assign rsp_code = rsp_err ? RESP_ERR : i_S_SResp;
  assign rsp_data = rsp_err ? '0 : i_S_SData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_M0_SResp <= RESP_NULL;
      o_M0_SData <= '0;
      o_M1_SResp <= RESP_NULL;
      o_M1_SData <= '0;
    end else begin
      o_M0_SResp <= RESP_NULL;
      o_M0_SData <= '0;
      o_M1_SResp <= RESP_NULL;
      o_M1_SData <= '0;
      if (rsp_fire && !owner) begin
        o_M0_SResp <= rsp_code;
        o_M0_SData <= rsp_data;
      end
      if (rsp_fire && owner) begin
        o_M1_SResp <= rsp_code;
        o_M1_SData <= rsp_data;
      end
    end
  end

  always_comb begin
    o_S_MAddr   = '0;
    o_S_MCmd    = CMD_IDLE;
    o_S_MData   = '0;
    o_S_MByteEn = '0;
    if (state == S_ISSUE) begin
      o_S_MAddr   = slot_addr[owner];
      o_S_MCmd    = slot_cmd[owner];
      o_S_MData   = slot_data[owner];
      o_S_MByteEn = slot_ben[owner];
    end
  end

endmodule
